// File: rtl/nt_subckt_bist_ctrl.sv
// Logic BIST controller: LFSR stimulus into a pipelined subcircuit, MISR compaction of its response.
// Optional `BIST_ABORT_EN adds an abort input that cancels a run in progress.
module nt_subckt_bist_ctrl #(
  parameter int LFSR_W = 16,
  parameter int LAT    = 3,
  parameter int CNT_W  = 10
) (
  input  logic              I1294_clk,
  input  logic              I1301_rst,
  input  logic              start,
`ifdef BIST_ABORT_EN
  input  logic              abort,
`endif
  input  logic [CNT_W-1:0]  pat_count,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] golden,
  input  logic              dut_resp,
  output logic [3:0]        stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LFSR_W-1:0] signature
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W:0] LAT_C = (CNT_W+1)'(LAT);
  localparam logic [CNT_W:0] ONE_C = (CNT_W+1)'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W:0]    r_cnt;
  logic [CNT_W:0]    w_cnt_next;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  w_n_next;
  logic [LFSR_W-1:0] r_golden;
  logic [LFSR_W-1:0] w_golden_next;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] r_misr;
  logic [LFSR_W-1:0] w_misr_next;
  logic [3:0]        r_stim;
  logic [3:0]        w_stim_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_pass;
  logic              w_pass_next;

  logic [LFSR_W-1:0] w_seed_eff;
  logic [CNT_W:0]    w_n_ext;
  logic [CNT_W:0]    w_cnt_inc;
  logic [CNT_W:0]    w_last;
  logic              w_abort;

`ifdef BIST_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // An all-zero Fibonacci LFSR would lock up, so a zero seed becomes 1.
  assign w_seed_eff = (seed == '0) ? LFSR_W'(1) : seed;
  assign w_n_ext    = {1'b0, r_n};
  assign w_cnt_inc  = r_cnt + ONE_C;
  assign w_last     = w_n_ext + LAT_C - ONE_C;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  always_ff @(posedge I1294_clk or negedge I1301_rst) begin
    if (!I1301_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_n_next      = r_n;
    w_golden_next = r_golden;
    w_lfsr_next   = r_lfsr;
    w_misr_next   = r_misr;
    w_pass_next   = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (r_state == ST_DONE) begin
          w_pass_next = r_pass;
        end
        if (start) begin
          w_n_next      = pat_count;
          w_golden_next = golden;
          w_cnt_next    = '0;
          w_misr_next   = '0;
          w_lfsr_next   = w_seed_eff;
          if (pat_count == '0) begin
            w_state_next = ST_DONE;
            w_pass_next  = (golden == '0);
          end else begin
            w_state_next = ST_RUN;
            w_pass_next  = 1'b0;
          end
        end
      end

      ST_RUN, ST_FLUSH: begin
        if (w_abort) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (r_state == ST_RUN) begin
            w_lfsr_next = lfsr_step(r_lfsr);
          end
          // Response to pattern k arrives LAT cycles later, i.e. while cnt == k+LAT.
          if (r_cnt >= LAT_C) begin
            w_misr_next = lfsr_step(r_misr) ^ {{(LFSR_W-1){1'b0}}, dut_resp};
          end
          if (r_cnt == w_last) begin
            w_state_next = ST_DONE;
            w_pass_next  = (w_misr_next == r_golden);
          end else if (w_cnt_inc < w_n_ext) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_FLUSH;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next == ST_RUN) || (w_state_next == ST_FLUSH);
    w_done_next = (w_state_next == ST_DONE);
    w_stim_next = (w_state_next == ST_RUN) ? w_lfsr_next[3:0] : 4'h0;
  end

  always_ff @(posedge I1294_clk or negedge I1301_rst) begin
    if (!I1301_rst) begin
      r_cnt    <= '0;
      r_n      <= '0;
      r_golden <= '0;
      r_lfsr   <= '0;
      r_misr   <= '0;
      r_stim   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_n      <= w_n_next;
      r_golden <= w_golden_next;
      r_lfsr   <= w_lfsr_next;
      r_misr   <= w_misr_next;
      r_stim   <= w_stim_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_pass   <= w_pass_next;
    end
  end

  assign stim      = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;

endmodule
